pl_hazard_ctrl: RTL and testbench
=================================

# pl_hazard_ctrl

Parametrised pipeline control block for the next-generation 5-stage pipelined CPU. It owns the program counter and drives the enables, flushes and bubbles of the IF/ID and ID/EX registers. It detects RAW and load-use hazards and redirects on taken branches. It also produces registered EX-stage forwarding selects and WB→ID bypass selects, and keeps saturating stall and flush counters. It sits between the control unit and the pipeline registers, replacing the free-running PC and unconditional pipeline-register enables.

## Interface
Parameters:
- XLEN, 64, PC / branch-target width
- RA_W, 5, register-address width
- RESET_PC, 0, PC value after reset
- CNT_W, 32, performance-counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  global advance; 0 freezes all state
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- ex_rd  in  RA_W; ex_reg_write, ex_mem_read  in  1  destination and controls of the instruction in EX
- mem_rd  in  RA_W; mem_reg_write  in  1  destination and control of the instruction in MEM
- wb_rd  in  RA_W; wb_reg_write  in  1  destination and control of the instruction in WB
- ex_br_taken  in  1  branch resolved taken in EX
- ex_br_target  in  XLEN  branch target
- pc  out  XLEN  current fetch address
- if_id_en, id_ex_en  out  1  pipeline-register load enables
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_bubble  out  1  load zeroed controls into ID/EX
- fwd_a, fwd_b  out  2  registered EX operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
- wb_byp_a, wb_byp_b  out  1  combinational; ID read data is replaced by WB write data
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Register x0 never matches. Every comparison also requires rd != 0 and the corresponding use/write flag.
- Priority, highest first: Reset > Run=0 > branch redirect > stall > normal advance.
- **Normal:** pc <= pc + 4, if_id_en=1, id_ex_en=1, no flush, no bubble.
- **Branch** (ex_br_taken=1): pc <= ex_br_target, if_id_flush=1, id_ex_bubble=1, flush_cnt += 1. A concurrent stall is discarded and stall_cnt does not increment.
- **Load-use stall:** ex_mem_read=1 and ex_rd matches a used ID source register.
  - pc holds, if_id_en=0, id_ex_bubble=1, stall_cnt += 1.
- **Forwarding:** fwd_a/fwd_b are computed in ID and registered together with the ID/EX load, so they are valid in EX.
  - Match with ex_rd and ex_reg_write (not a load) → 10.
  - Else match with mem_rd and mem_reg_write → 01.
  - Else → 00.
  - The EX match wins over the MEM match.
- **Bubble:** when ID/EX loads a bubble, fwd_a/fwd_b load 00.
- **WB bypass:** wb_byp_a/b = 1 when wb_reg_write=1 and wb_rd equals the used rs1/rs2.
- **Run=0:** if_id_en = id_ex_en = 0, flush/bubble = 0. PC, fwd registers and counters hold.
- **Counters:** saturate at all-ones and never wrap.

## Timing
- Reset values: pc=RESET_PC, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0. if_id_en, id_ex_en, if_id_flush and id_ex_bubble are all 0 during the reset cycle.
- Enable/flush/bubble/byp outputs are combinational from the current inputs and take effect at the next rising edge.
- A load-use stall lasts exactly 1 cycle when forwarding is present. On the following cycle the load is in MEM and the dependent instruction gets fwd=01.
- Branch penalty: 2 instructions are squashed (IF/ID and ID/EX), and the target is fetched the cycle after ex_br_taken.
- Reset asserted mid-stall or mid-redirect overrides everything. The pending redirect is lost.
- PC arithmetic is modulo 2^XLEN. The target is taken verbatim, with no alignment check.

## Configuration
- `PL_HAZARD_FWD_EN` defined: forwarding logic is present as described.
- Not defined:
  - fwd_a/fwd_b are tied to 00.
  - A stall is raised for any used source matching ex_rd (with ex_reg_write) or mem_rd (with mem_reg_write). A dependent instruction therefore stalls up to 2 cycles; the WB bypass covers the last one.
  - Branch priority over stall is unchanged.

## Structure
- Shared package pl_pkg: the FWD_RF / FWD_MEMWB / FWD_EXMEM 2-bit constants and the NOP instruction constant.
- One sub-module, pl_hazard_detect: purely combinational; computes the raw match flags, the stall request and the next fwd codes.
- The top holds the PC, fwd registers, counters and priority logic.

## Test plan
- **Reset:** RESET_PC=0x100, Reset high 2 cycles → pc=0x100, counters 0, fwd 00. After release, pc=0x104, 0x108 on successive cycles.
- **Load-use:** ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with pc held, if_id_en=0, id_ex_bubble=1. stall_cnt=1, and the next cycle's fwd_a=01.
- **EX/MEM forward:** ex_reg_write=1, ex_rd=3 and mem_reg_write=1, mem_rd=3, id_rs2=3 → fwd_b=10 after the edge, no stall. With ex_rd=0 instead → fwd_b=01.
- **Branch over stall:** ex_br_taken=1, target 0x2000, with a load-use condition also true → pc=0x2000, flush and bubble asserted, flush_cnt=1, stall_cnt unchanged.
- **Run=0 freeze:** Run low 3 cycles → pc, counters and fwd unchanged, enables 0.
- **Saturation and no-forwarding build:** CNT_W=2, 5 consecutive stalls → stall_cnt=3. Without `PL_HAZARD_FWD_EN`, mem_rd=4 matching id_rs1 → 1 stall cycle and fwd_a=00.

Source files
------------

// File: rtl/pl_pkg.sv
// Shared pipeline-control definitions: forwarding select codes, the NOP
// instruction word and the decoded control mode used by pl_hazard_ctrl.
package pl_pkg;

    localparam int unsigned FWD_W = 2;

    // EX operand source selects
    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

    // addi x0, x0, 0 -- what IF/ID holds after a flush
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Per-cycle pipeline action, highest-priority condition wins
    typedef enum logic [2:0] {
        CTL_RESET,
        CTL_FREEZE,
        CTL_REDIRECT,
        CTL_STALL,
        CTL_ADVANCE
    } pl_ctl_e;

endpackage

// File: rtl/pl_hazard_detect.sv
// Combinational hazard detection: register-match flags, stall request,
// next EX forwarding selects and WB->ID bypass selects.
// Build option: PL_HAZARD_FWD_EN enables EX/MEM and MEM/WB forwarding;
// without it every in-flight dependency stalls and fwd selects are 00.
module pl_hazard_detect
    import pl_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RA_W-1:0]  ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic [RA_W-1:0]  mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic [RA_W-1:0]  wb_rd_i,
    input  logic             wb_reg_write_i,
    output logic             stall_req_o,
    output logic [FWD_W-1:0] fwd_a_o,
    output logic [FWD_W-1:0] fwd_b_o,
    output logic             wb_byp_a_o,
    output logic             wb_byp_b_o
);

    // A used source matches a destination; x0 never matches
    function automatic logic src_hit(input logic use_src,
                                     input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] rd);
        return use_src && (rd != '0) && (rd == src);
    endfunction

    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, rs1_wb, rs2_wb;

    assign rs1_ex  = src_hit(id_use_rs1_i, id_rs1_i, ex_rd_i);
    assign rs2_ex  = src_hit(id_use_rs2_i, id_rs2_i, ex_rd_i);
    assign rs1_mem = src_hit(id_use_rs1_i, id_rs1_i, mem_rd_i);
    assign rs2_mem = src_hit(id_use_rs2_i, id_rs2_i, mem_rd_i);
    assign rs1_wb  = src_hit(id_use_rs1_i, id_rs1_i, wb_rd_i);
    assign rs2_wb  = src_hit(id_use_rs2_i, id_rs2_i, wb_rd_i);

    assign wb_byp_a_o = wb_reg_write_i && rs1_wb;
    assign wb_byp_b_o = wb_reg_write_i && rs2_wb;

`ifdef PL_HAZARD_FWD_EN
    logic ex_alu;

    // Only a non-load result in EX can be forwarded from EX/MEM next cycle
    assign ex_alu      = ex_reg_write_i && !ex_mem_read_i;
    assign stall_req_o = ex_mem_read_i && (rs1_ex || rs2_ex);

    // Youngest producer (EX) wins over MEM
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (ex_alu && rs1_ex) begin
            fwd_a_o = FWD_EXMEM;
        end else if (mem_reg_write_i && rs1_mem) begin
            fwd_a_o = FWD_MEMWB;
        end
        if (ex_alu && rs2_ex) begin
            fwd_b_o = FWD_EXMEM;
        end else if (mem_reg_write_i && rs2_mem) begin
            fwd_b_o = FWD_MEMWB;
        end
    end
`else
    // Any producer still in EX or MEM holds the consumer in ID
    assign stall_req_o = ((ex_reg_write_i || ex_mem_read_i) && (rs1_ex || rs2_ex))
                      || (mem_reg_write_i && (rs1_mem || rs2_mem));
    assign fwd_a_o     = FWD_RF;
    assign fwd_b_o     = FWD_RF;
`endif

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline control for the 5-stage CPU: owns the PC, drives IF/ID and
// ID/EX enables/flush/bubble, registers EX forwarding selects and keeps
// saturating stall/flush counters.
// Build option: PL_HAZARD_FWD_EN (see pl_hazard_detect).
module pl_hazard_ctrl
    import pl_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     RA_W     = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_br_taken,
    input  logic [XLEN-1:0]  ex_br_target,
    output logic [XLEN-1:0]  pc,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             wb_byp_a,
    output logic             wb_byp_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             stall_req;
    logic [FWD_W-1:0] fwd_a_nx, fwd_b_nx;
    pl_ctl_e          mode;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [FWD_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    pl_hazard_detect #(
        .RA_W (RA_W)
    ) u_detect (
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use_rs1),
        .id_use_rs2_i    (id_use_rs2),
        .ex_rd_i         (ex_rd),
        .ex_reg_write_i  (ex_reg_write),
        .ex_mem_read_i   (ex_mem_read),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .stall_req_o     (stall_req),
        .fwd_a_o         (fwd_a_nx),
        .fwd_b_o         (fwd_b_nx),
        .wb_byp_a_o      (wb_byp_a),
        .wb_byp_b_o      (wb_byp_b)
    );

    // Priority decode: Reset > freeze > redirect > stall > advance
    always_comb begin
        mode = CTL_ADVANCE;
        if (Reset) begin
            mode = CTL_RESET;
        end else if (!Run) begin
            mode = CTL_FREEZE;
        end else if (ex_br_taken) begin
            mode = CTL_REDIRECT;
        end else if (stall_req) begin
            mode = CTL_STALL;
        end
    end

    // Pipeline-register controls and next state for PC, fwd and counters
    always_comb begin
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_d         = pc_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        case (mode)
            CTL_REDIRECT: begin
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                pc_d         = ex_br_target;
                fwd_a_d      = FWD_RF;
                fwd_b_d      = FWD_RF;
                flush_cnt_d  = sat_inc(flush_cnt_q);
            end
            CTL_STALL: begin
                id_ex_en     = 1'b1;
                id_ex_bubble = 1'b1;
                fwd_a_d      = FWD_RF;
                fwd_b_d      = FWD_RF;
                stall_cnt_d  = sat_inc(stall_cnt_q);
            end
            CTL_ADVANCE: begin
                if_id_en = 1'b1;
                id_ex_en = 1'b1;
                pc_d     = pc_q + XLEN'(4);
                fwd_a_d  = fwd_a_nx;
                fwd_b_d  = fwd_b_nx;
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl; expectations follow the build option
// PL_HAZARD_FWD_EN. Counters are 2 bits wide so saturation is reachable.
module tb_pl_hazard_ctrl;
    import pl_pkg::*;

    localparam int unsigned     XLEN   = 64;
    localparam int unsigned     RA_W   = 5;
    localparam int unsigned     CNT_W  = 2;
    localparam logic [XLEN-1:0] RST_PC = 64'h100;

    logic            Clk = 1'b0;
    logic            Reset, Run;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
    logic            mem_reg_write, wb_reg_write, ex_br_taken;
    logic [XLEN-1:0] ex_br_target, pc;
    logic            if_id_en, id_ex_en, if_id_flush, id_ex_bubble;
    logic [1:0]      fwd_a, fwd_b;
    logic            wb_byp_a, wb_byp_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [63:0] exp_pc;
    logic [63:0] exp_st;
    logic [63:0] exp_fl;
    logic [63:0] exp_fa;

    pl_hazard_ctrl #(
        .XLEN     (XLEN),
        .RA_W     (RA_W),
        .RESET_PC (RST_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Run           (Run),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .ex_br_taken   (ex_br_taken),
        .ex_br_target  (ex_br_target),
        .pc            (pc),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .wb_byp_a      (wb_byp_a),
        .wb_byp_b      (wb_byp_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0;
        wb_rd = '0; wb_reg_write = 1'b0;
        ex_br_taken = 1'b0; ex_br_target = '0;
    endtask

    function automatic logic [63:0] sat(input logic [63:0] v);
        return (v >= 64'd3) ? 64'd3 : v + 64'd1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Run = 1'b1; clr();
        exp_st = 0; exp_fl = 0; exp_fa = 0;
        tick(); tick();

        // reset state
        check("rst_if_id_en", 64'(if_id_en), 0);
        check("rst_id_ex_en", 64'(id_ex_en), 0);
        check("rst_flush", 64'(if_id_flush), 0);
        check("rst_bubble", 64'(id_ex_bubble), 0);
        check("rst_pc", pc, 64'h100);
        check("rst_stall_cnt", 64'(stall_cnt), 0);
        check("rst_flush_cnt", 64'(flush_cnt), 0);
        check("rst_fwd_a", 64'(fwd_a), 0);
        check("rst_fwd_b", 64'(fwd_b), 0);

        Reset = 1'b0; #1;
        check("adv_if_id_en", 64'(if_id_en), 1);
        check("adv_id_ex_en", 64'(id_ex_en), 1);
        tick(); check("adv_pc1", pc, 64'h104);
        tick(); check("adv_pc2", pc, 64'h108);
        exp_pc = 64'h108;

        // load-use on rs1
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1'b1; #1;
        check("lu_if_id_en", 64'(if_id_en), 0);
        check("lu_bubble", 64'(id_ex_bubble), 1);
        check("lu_flush", 64'(if_id_flush), 0);
        tick(); exp_st = sat(exp_st);
        check("lu_pc_hold", pc, exp_pc);
        check("lu_stall_cnt", 64'(stall_cnt), exp_st);
        check("lu_fwd_a", 64'(fwd_a), 0);
        // load now in MEM
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 0; mem_rd = 5; mem_reg_write = 1'b1; #1;
`ifdef PL_HAZARD_FWD_EN
        check("lu2_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("lu2_fwd_a", 64'(fwd_a), 64'(FWD_MEMWB));
`else
        check("lu2_if_id_en", 64'(if_id_en), 0);
        tick(); exp_st = sat(exp_st);
        check("lu2_fwd_a", 64'(fwd_a), 0);
`endif
        check("lu2_pc", pc, exp_pc);
        check("lu2_stall_cnt", 64'(stall_cnt), exp_st);
        // load now in WB: bypass covers the read
        mem_reg_write = 1'b0; mem_rd = 0; wb_rd = 5; wb_reg_write = 1'b1; #1;
        check("lu3_byp_a", 64'(wb_byp_a), 1);
        check("lu3_byp_b", 64'(wb_byp_b), 0);
        check("lu3_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("lu3_pc", pc, exp_pc);
        clr();

        // EX and MEM both produce rs2
        ex_reg_write = 1'b1; ex_rd = 3; mem_reg_write = 1'b1; mem_rd = 3; id_rs2 = 3; id_use_rs2 = 1'b1; #1;
`ifdef PL_HAZARD_FWD_EN
        check("exm_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("exm_fwd_b", 64'(fwd_b), 64'(FWD_EXMEM));
`else
        check("exm_if_id_en", 64'(if_id_en), 0);
        tick(); exp_st = sat(exp_st);
        check("exm_fwd_b", 64'(fwd_b), 0);
`endif
        ex_rd = 0; #1;
`ifdef PL_HAZARD_FWD_EN
        check("mem_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("mem_fwd_b", 64'(fwd_b), 64'(FWD_MEMWB));
`else
        check("mem_if_id_en", 64'(if_id_en), 0);
        tick(); exp_st = sat(exp_st);
        check("mem_fwd_b", 64'(fwd_b), 0);
`endif
        check("exm_pc", pc, exp_pc);
        check("exm_stall_cnt", 64'(stall_cnt), exp_st);
        clr();

        // branch beats a concurrent load-use stall
        ex_br_taken = 1'b1; ex_br_target = 64'h2000;
        ex_mem_read = 1'b1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1'b1; #1;
        check("br_flush", 64'(if_id_flush), 1);
        check("br_bubble", 64'(id_ex_bubble), 1);
        tick(); exp_pc = 64'h2000; exp_fl = sat(exp_fl);
        check("br_pc", pc, exp_pc);
        check("br_flush_cnt", 64'(flush_cnt), exp_fl);
        check("br_stall_cnt", 64'(stall_cnt), exp_st);
        check("br_fwd_a", 64'(fwd_a), 0);
        clr(); tick(); exp_pc = exp_pc + 4;
        check("br_target_next", pc, exp_pc);

        // set up a dependency, then freeze with a branch pending
        ex_reg_write = 1'b1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1'b1; #1;
        tick();
`ifdef PL_HAZARD_FWD_EN
        exp_pc = exp_pc + 4; exp_fa = 64'(FWD_EXMEM);
`else
        exp_st = sat(exp_st); exp_fa = 0;
`endif
        check("frz_setup_fwd_a", 64'(fwd_a), exp_fa);
        Run = 1'b0; ex_br_taken = 1'b1; ex_br_target = 64'h4000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_if_id_en", 64'(if_id_en), 0);
            check("frz_id_ex_en", 64'(id_ex_en), 0);
            check("frz_flush", 64'(if_id_flush), 0);
            check("frz_bubble", 64'(id_ex_bubble), 0);
            tick();
            check("frz_pc", pc, exp_pc);
            check("frz_stall_cnt", 64'(stall_cnt), exp_st);
            check("frz_flush_cnt", 64'(flush_cnt), exp_fl);
            check("frz_fwd_a", 64'(fwd_a), exp_fa);
        end
        Run = 1'b1; clr();

        // consecutive stalls saturate the 2-bit counter
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); exp_st = sat(exp_st);
            check("sat_stall_cnt", 64'(stall_cnt), exp_st);
            check("sat_pc_hold", pc, exp_pc);
        end
        check("sat_final", 64'(stall_cnt), 3);
        clr();

        // x0 and unused sources never match
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1'b1; #1;
        check("x0_if_id_en", 64'(if_id_en), 1);
        check("x0_bubble", 64'(id_ex_bubble), 0);
        ex_rd = 6; id_rs1 = 6; id_use_rs1 = 1'b0; id_rs2 = 6; id_use_rs2 = 1'b0; #1;
        check("nouse_if_id_en", 64'(if_id_en), 1);
        clr();
        wb_reg_write = 1'b1; wb_rd = 0; id_rs1 = 0; id_use_rs1 = 1'b1; #1;
        check("x0_byp_a", 64'(wb_byp_a), 0);
        clr();

        // producer of rs1 sitting in MEM
        mem_reg_write = 1'b1; mem_rd = 4; id_rs1 = 4; id_use_rs1 = 1'b1; #1;
`ifdef PL_HAZARD_FWD_EN
        check("m4_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("m4_fwd_a", 64'(fwd_a), 64'(FWD_MEMWB));
`else
        check("m4_if_id_en", 64'(if_id_en), 0);
        tick(); exp_st = sat(exp_st);
        check("m4_fwd_a", 64'(fwd_a), 0);
`endif
        check("m4_pc", pc, exp_pc);
        mem_reg_write = 1'b0; mem_rd = 0; wb_rd = 4; wb_reg_write = 1'b1; #1;
        check("m4_byp_a", 64'(wb_byp_a), 1);
        check("m4wb_if_id_en", 64'(if_id_en), 1);
        tick(); exp_pc = exp_pc + 4;
        check("m4wb_pc", pc, exp_pc);
        check("m4wb_fwd_a", 64'(fwd_a), 0);
        clr();

        // unaligned target taken verbatim, then PC wraps modulo 2^64
        ex_br_taken = 1'b1; ex_br_target = 64'hFFFF_FFFF_FFFF_FFFE; #1;
        tick(); exp_fl = sat(exp_fl);
        check("wrap_target", pc, 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_flush_cnt", 64'(flush_cnt), exp_fl);
        clr(); tick();
        check("wrap_pc", pc, 64'h2);

        // reset during redirect and stall wins
        ex_br_taken = 1'b1; ex_br_target = 64'h3000;
        ex_mem_read = 1'b1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1'b1; Reset = 1'b1; #1;
        check("rr_flush", 64'(if_id_flush), 0);
        check("rr_bubble", 64'(id_ex_bubble), 0);
        check("rr_if_id_en", 64'(if_id_en), 0);
        tick();
        check("rr_pc", pc, 64'h100);
        check("rr_stall_cnt", 64'(stall_cnt), 0);
        check("rr_flush_cnt", 64'(flush_cnt), 0);
        Reset = 1'b0; clr(); tick();
        check("rr_pc_next", pc, 64'h104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
